fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_pkg.sv | 13 +
 rtl/fetchq_mem.sv | 27 ++
 rtl/fetch_queue.sv | 122 ++++++++++++
 tb/tb_fetch_queue.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared pipeline definitions for the fetch queue: bubble instruction and queue entry layout.
package fetch_queue_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetchq_entry_t;

endpackage

// File: rtl/fetchq_mem.sv
// Entry storage for the fetch queue: DEPTH registers, one write port, one asynchronous read port.
module fetchq_mem
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  fetchq_entry_t wr_data_i,
  input  logic [AW-1:0] rd_addr_i,
  output fetchq_entry_t rd_data_o
);

  // Contents are never reset; validity is tracked by the queue's count.
  fetchq_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between fetch and decode, with flush and a NOP bubble when empty.
// Optional same-cycle empty-queue bypass is enabled by defining FETCHQ_BYPASS_EN.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter int               DEPTH = 4,
  parameter logic [WIDTH-1:0] NOP   = WIDTH'(NOP_INSTR),
  localparam int              CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_valid,
  output logic             push_ready,
  input  logic [WIDTH-1:0] push_pc,
  input  logic [WIDTH-1:0] push_instr,
  output logic             pop_valid,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] pop_pc,
  output logic [WIDTH-1:0] pop_instr,
  input  logic             flush,
  output logic [CW-1:0]    count
);

  localparam int            PW   = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [CW-1:0] count_q, count_d;

  fetchq_entry_t wrEntry;
  fetchq_entry_t rdEntry;

  logic stored;
  logic bypass;
  logic pushFire;
  logic popFire;
  logic memWrite;
  logic memRead;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  fetchq_mem #(
    .DEPTH(DEPTH)
  ) u_mem (
    .clk      (clk),
    .wr_en_i  (memWrite),
    .wr_addr_i(wrPtr_q),
    .wr_data_i(wrEntry),
    .rd_addr_i(rdPtr_q),
    .rd_data_o(rdEntry)
  );

  assign wrEntry.pc    = XLEN'(push_pc);
  assign wrEntry.instr = XLEN'(push_instr);

  assign stored     = (count_q != '0);
  assign push_ready = (count_q < FULL);
  assign count      = count_q;

`ifdef FETCHQ_BYPASS_EN
  assign bypass = !stored && push_valid && !flush;
`else
  assign bypass = 1'b0;
`endif

  assign pop_valid = stored || bypass;
  assign pushFire  = push_valid && push_ready && !flush;
  assign popFire   = pop_valid && pop_ready && !flush;

  // A bypassed instruction consumed in the same cycle never touches storage.
  assign memWrite = pushFire && !(bypass && pop_ready);
  assign memRead  = popFire && stored;

  always_comb begin
    pop_pc    = '0;
    pop_instr = NOP;
    if (bypass) begin
      pop_pc    = push_pc;
      pop_instr = push_instr;
    end else if (stored) begin
      pop_pc    = WIDTH'(rdEntry.pc);
      pop_instr = WIDTH'(rdEntry.instr);
    end
  end

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (memWrite) wrPtr_d = nextPtr(wrPtr_q);
      if (memRead)  rdPtr_d = nextPtr(rdPtr_q);
      case ({memWrite, memRead})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue: a DEPTH=4 instance for most scenarios
// and a DEPTH=3 instance for the streaming pointer-wrap scenario.
module tb_fetch_queue;

   logic clk;
   logic reset;

   logic        aPushValid, aPushReady, aPopValid, aPopReady, aFlush;
   logic [31:0] aPushPc, aPushInstr, aPopPc, aPopInstr;
   logic [2:0]  aCount;

   logic        bPushValid, bPushReady, bPopValid, bPopReady, bFlush;
   logic [31:0] bPushPc, bPushInstr, bPopPc, bPopInstr;
   logic [1:0]  bCount;

   int passCount = 0;
   int checkCount = 0;

   fetch_queue #(.WIDTH(32), .DEPTH(4)) dutA (
      .clk       (clk),
      .reset     (reset),
      .push_valid(aPushValid),
      .push_ready(aPushReady),
      .push_pc   (aPushPc),
      .push_instr(aPushInstr),
      .pop_valid (aPopValid),
      .pop_ready (aPopReady),
      .pop_pc    (aPopPc),
      .pop_instr (aPopInstr),
      .flush     (aFlush),
      .count     (aCount)
   );

   fetch_queue #(.WIDTH(32), .DEPTH(3)) dutB (
      .clk       (clk),
      .reset     (reset),
      .push_valid(bPushValid),
      .push_ready(bPushReady),
      .push_pc   (bPushPc),
      .push_instr(bPushInstr),
      .pop_valid (bPopValid),
      .pop_ready (bPopReady),
      .pop_pc    (bPopPc),
      .pop_instr (bPopInstr),
      .flush     (bFlush),
      .count     (bCount)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One comparison: counts the check, steps passCount on success, reports on failure
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
   endtask

   // Drive the DEPTH=4 instance's inputs and let combinational outputs settle
   task automatic applyStimulus(input logic pv, input logic [31:0] pc, input logic [31:0] instr,
                                input logic pr, input logic fl);
      aPushValid = pv;
      aPushPc    = pc;
      aPushInstr = instr;
      aPopReady  = pr;
      aFlush     = fl;
      #1;
   endtask

   // Advance one clock edge and land just after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Main directed sequence
   initial begin
      int pushIdx;
      int popIdx;
      reset = 1'b0;
      bPushValid = 1'b0; bPushPc = '0; bPushInstr = '0; bPopReady = 1'b0; bFlush = 1'b0;
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

      checkOutput("reset count", 32'(aCount), 32'd0);
      checkOutput("reset pop_valid", 32'(aPopValid), 32'd0);
      checkOutput("reset pop_instr", aPopInstr, 32'h13);
      checkOutput("reset pop_pc", aPopPc, 32'h0);
      checkOutput("reset push_ready", 32'(aPushReady), 32'd1);

      tick();
      reset = 1'b1;
      tick();

      // Fill four entries without popping
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 32'(i * 4), 32'h1000 + 32'(i * 4), 1'b0, 1'b0);
         tick();
      end
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      checkOutput("full count", 32'(aCount), 32'd4);
      checkOutput("full push_ready", 32'(aPushReady), 32'd0);

      applyStimulus(1'b1, 32'h10, 32'h1010, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      checkOutput("fifth push rejected count", 32'(aCount), 32'd4);

      // Drain in push order
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
         checkOutput("drain pop_valid", 32'(aPopValid), 32'd1);
         checkOutput("drain pop_pc", aPopPc, 32'(i * 4));
         checkOutput("drain pop_instr", aPopInstr, 32'h1000 + 32'(i * 4));
         tick();
      end
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      checkOutput("drained count", 32'(aCount), 32'd0);
      checkOutput("drained pop_valid", 32'(aPopValid), 32'd0);
      checkOutput("drained pop_pc", aPopPc, 32'h0);
      checkOutput("drained pop_instr", aPopInstr, 32'h13);

      // Flush dominates a simultaneous push and pop
      applyStimulus(1'b1, 32'h60, 32'h2060, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 32'h64, 32'h2064, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      checkOutput("pre-flush count", 32'(aCount), 32'd2);
      applyStimulus(1'b1, 32'h80, 32'h2080, 1'b1, 1'b1);
      tick();
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      checkOutput("post-flush count", 32'(aCount), 32'd0);
      checkOutput("post-flush pop_valid", 32'(aPopValid), 32'd0);
      checkOutput("post-flush pop_instr", aPopInstr, 32'h13);
      tick();
      applyStimulus(1'b1, 32'h90, 32'h2090, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      checkOutput("post-flush head not flushed pc", aPopPc, 32'h90);
      checkOutput("post-flush count one", 32'(aCount), 32'd1);
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      tick();
      checkOutput("post-flush emptied", 32'(aCount), 32'd0);

      // Empty-queue push with decode ready
      applyStimulus(1'b1, 32'h40, 32'h0050_0093, 1'b1, 1'b0);
`ifdef FETCHQ_BYPASS_EN
      checkOutput("bypass pop_valid", 32'(aPopValid), 32'd1);
      checkOutput("bypass pop_pc", aPopPc, 32'h40);
      checkOutput("bypass pop_instr", aPopInstr, 32'h0050_0093);
      tick();
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      checkOutput("bypass count", 32'(aCount), 32'd0);
      checkOutput("bypass after pop_valid", 32'(aPopValid), 32'd0);
`else
      checkOutput("latency same-cycle pop_valid", 32'(aPopValid), 32'd0);
      tick();
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      checkOutput("latency count", 32'(aCount), 32'd1);
      checkOutput("latency pop_valid", 32'(aPopValid), 32'd1);
      checkOutput("latency pop_pc", aPopPc, 32'h40);
      checkOutput("latency pop_instr", aPopInstr, 32'h0050_0093);
      tick();
      checkOutput("latency drained count", 32'(aCount), 32'd0);
`endif

      // Full queue, decode stalled: head must hold steady
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 32'h100 + 32'(i * 4), 32'h3100 + 32'(i * 4), 1'b0, 1'b0);
         tick();
      end
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         checkOutput("stall head pc", aPopPc, 32'h100);
         checkOutput("stall head instr", aPopInstr, 32'h3100);
         tick();
      end
      checkOutput("stall pop_valid", 32'(aPopValid), 32'd1);

      // Asynchronous reset mid-cycle, no edge in between
      #2;
      reset = 1'b0;
      #1;
      checkOutput("async reset count", 32'(aCount), 32'd0);
      checkOutput("async reset pop_valid", 32'(aPopValid), 32'd0);
      checkOutput("async reset pop_instr", aPopInstr, 32'h13);
      checkOutput("async reset push_ready", 32'(aPushReady), 32'd1);
      tick();
      reset = 1'b1;
      tick();

      // DEPTH=3 streaming across pointer wrap: stall three cycles, then pop continuously
      pushIdx = 0;
      popIdx = 0;
      for (int cyc = 0; cyc < 60 && popIdx < 10; cyc++) begin
         bPushValid = (pushIdx < 10);
         bPushPc    = 32'(pushIdx * 4);
         bPushInstr = 32'h4000 + 32'(pushIdx * 4);
         bPopReady  = (cyc >= 3);
         #1;
         checkOutput("stream count bound", 32'(bCount <= 2'd3), 32'd1);
         if (bPopValid && bPopReady) begin
            checkOutput("stream pop_pc", bPopPc, 32'(popIdx * 4));
            checkOutput("stream pop_instr", bPopInstr, 32'h4000 + 32'(popIdx * 4));
            popIdx++;
         end
         if (bPushValid && bPushReady) pushIdx++;
         tick();
      end
      bPushValid = 1'b0;
      bPopReady  = 1'b0;
      checkOutput("stream all popped", 32'(popIdx), 32'd10);
      #1;
      checkOutput("stream final count", 32'(bCount), 32'd0);

      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
